// File: rtl/serial_tx.sv
`default_nettype none
// ============================================================================
// Module   : serial_tx
// Purpose  : Parallel-to-serial transmitter. Accepts one DATAWIDTH-bit word
//            over a valid/ready handshake, shifts it out one bit per clock on
//            a framed serial line, then pulses done for one cycle.
// Ports    : Clk      - clock, rising edge
//            Rst      - synchronous active-high reset
//            d        - parallel word, sampled on the accepting edge only
//            d_valid  - producer offers d
//            d_ready  - high only while idle
//            sdata    - serial bit, 0 whenever sframe is 0
//            sframe   - high for DATAWIDTH consecutive cycles per word
//            done     - one-cycle pulse after the last bit
// Revision : 1.0 - initial release
// ============================================================================
module serial_tx #(
   parameter int DATAWIDTH = 2,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic                 Clk,
   input  logic                 Rst,
   input  logic [DATAWIDTH-1:0] d,
   input  logic                 d_valid,
   output logic                 d_ready,
   output logic                 sdata,
   output logic                 sframe,
   output logic                 done
);

   // A one-bit word still needs a one-bit counter.
   localparam int                c_CNT_W = (DATAWIDTH > 1) ? $clog2(DATAWIDTH) : 1;
   localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(DATAWIDTH - 1);
   localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t               r_state;
   state_t               w_next_state;
   logic [DATAWIDTH-1:0] r_shreg;
   logic [c_CNT_W-1:0]   r_cnt;
   logic                 w_head;

   // Head bit of the shift register in send order.
   generate
      if (MSB_FIRST) begin : g_msb_first
         assign w_head = r_shreg[DATAWIDTH-1];
      end else begin : g_lsb_first
         assign w_head = r_shreg[0];
      end
   endgenerate

   // State register plus datapath (shift register and bit counter).
   always_ff @(posedge Clk) begin
      if (Rst) begin
         r_state <= IDLE;
         r_shreg <= '0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_next_state;
         case (r_state)
            IDLE: begin
               if (d_valid) begin
                  r_shreg <= d;
                  r_cnt   <= '0;
               end
            end
            SHIFT: begin
               // Zero-fill shift moves the next bit into the head position.
               if (MSB_FIRST) begin
                  r_shreg <= r_shreg << 1;
               end else begin
                  r_shreg <= r_shreg >> 1;
               end
               if (r_cnt != c_LAST) begin
                  r_cnt <= r_cnt + c_ONE;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Next state and outputs; outputs depend on registered state only.
   always_comb begin
      w_next_state = r_state;
      d_ready      = 1'b0;
      sframe       = 1'b0;
      sdata        = 1'b0;
      done         = 1'b0;
      case (r_state)
         IDLE: begin
            d_ready = 1'b1;
            if (d_valid) begin
               w_next_state = SHIFT;
            end
         end
         SHIFT: begin
            sframe = 1'b1;
            sdata  = w_head;
            if (r_cnt == c_LAST) begin
               w_next_state = DONE;
            end
         end
         DONE: begin
            done         = 1'b1;
            w_next_state = IDLE;
         end
         default: begin
            w_next_state = IDLE;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_serial_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_tx
// Purpose  : Self-checking bench for serial_tx. Three instances run side by
//            side: 8-bit MSB-first, 8-bit LSB-first (sharing stimulus) and
//            1-bit. Each cycle their outputs are compared against a model
//            that derives expected outputs from the accept edge of the
//            current word.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_serial_tx;

   logic       Clk = 1'b0;
   logic       rst_a = 1'b0;
   logic       dv_a  = 1'b0;
   logic [7:0] d_a   = 8'h00;
   logic       rst_b = 1'b0;
   logic       dv_b  = 1'b0;
   logic [0:0] d_b   = 1'b0;

   logic [2:0] rdy;
   logic [2:0] sd;
   logic [2:0] sf;
   logic [2:0] dn;

   int errors = 0;
   int checks = 0;

   always #5 Clk = ~Clk;

   serial_tx #(.DATAWIDTH(8), .MSB_FIRST(1'b1)) u_msb (
      .Clk(Clk), .Rst(rst_a), .d(d_a), .d_valid(dv_a),
      .d_ready(rdy[0]), .sdata(sd[0]), .sframe(sf[0]), .done(dn[0])
   );

   serial_tx #(.DATAWIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
      .Clk(Clk), .Rst(rst_a), .d(d_a), .d_valid(dv_a),
      .d_ready(rdy[1]), .sdata(sd[1]), .sframe(sf[1]), .done(dn[1])
   );

   serial_tx #(.DATAWIDTH(1), .MSB_FIRST(1'b1)) u_one (
      .Clk(Clk), .Rst(rst_b), .d(d_b), .d_valid(dv_b),
      .d_ready(rdy[2]), .sdata(sd[2]), .sframe(sf[2]), .done(dn[2])
   );

   // ---------------------------------------------------------------- model
   // A word accepted at edge t0 shows bit k after edge t0+k (k < W),
   // done after edge t0+W, and idle from edge t0+W+1 on.
   int         wid   [3] = '{8, 8, 1};
   bit         msbf  [3] = '{1'b1, 1'b0, 1'b1};
   bit         has   [3] = '{1'b0, 1'b0, 1'b0};
   bit         armed [3] = '{1'b0, 1'b0, 1'b0};
   int         t0    [3] = '{0, 0, 0};
   logic [7:0] word  [3];
   int         edge_n = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h edge=%0d", tag, got, exp, edge_n);
      end
   endtask

   task automatic model_edge(input int i, input logic r, input logic v, input logic [7:0] w);
      bit idle_before;
      idle_before = !has[i] || ((edge_n - 1 - t0[i]) >= wid[i] + 1);
      if (r) begin
         has[i]   = 1'b0;
         armed[i] = 1'b1;
      end else if (v && idle_before) begin
         has[i]  = 1'b1;
         t0[i]   = edge_n;
         word[i] = w;
      end
   endtask

   task automatic check_unit(input int i);
      int   k;
      logic e_sf, e_dn, e_rdy, e_sd;
      k     = edge_n - t0[i];
      e_sf  = has[i] && (k < wid[i]);
      e_dn  = has[i] && (k == wid[i]);
      e_rdy = !has[i] || (k >= wid[i] + 1);
      e_sd  = 1'b0;
      if (e_sf) e_sd = msbf[i] ? word[i][wid[i]-1-k] : word[i][k];
      check($sformatf("u%0d_sframe", i), 32'(sf[i]),  32'(e_sf));
      check($sformatf("u%0d_sdata", i),  32'(sd[i]),  32'(e_sd));
      check($sformatf("u%0d_done", i),   32'(dn[i]),  32'(e_dn));
      check($sformatf("u%0d_ready", i),  32'(rdy[i]), 32'(e_rdy));
   endtask

   // One clock: drive inputs, let the edge happen, update model, check.
   task automatic step(input logic r, input logic v, input logic [7:0] w,
                       input logic rb, input logic vb, input logic db);
      rst_a = r;  dv_a = v;  d_a = w;
      rst_b = rb; dv_b = vb; d_b = db;
      @(posedge Clk);
      edge_n++;
      model_edge(0, r, v, w);
      model_edge(1, r, v, w);
      model_edge(2, rb, vb, {7'b0, db});
      @(negedge Clk);
      for (int i = 0; i < 3; i++) begin
         if (armed[i]) check_unit(i);
      end
   endtask

   initial begin
      // Reset; 1-bit unit gets a continuous stream of 1s during directed part.
      step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

      // 8'hA5, single accept, then idle.
      step(1'b0, 1'b1, 8'hA5, 1'b0, 1'b1, 1'b1);
      for (int c = 0; c < 11; c++) step(1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b1);

      // 8'h81 then d changes to 00 after the accepting edge.
      step(1'b0, 1'b1, 8'h81, 1'b0, 1'b1, 1'b1);
      for (int c = 0; c < 11; c++) step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);

      // d_valid held high: F0 then 0F, second accept ten edges later.
      step(1'b0, 1'b1, 8'hF0, 1'b0, 1'b1, 1'b1);
      for (int c = 0; c < 21; c++) step(1'b0, 1'b1, 8'h0F, 1'b0, 1'b1, 1'b1);
      step(1'b0, 1'b0, 8'h0F, 1'b0, 1'b0, 1'b0);
      for (int c = 0; c < 10; c++) step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

      // Reset at E0+3 of an FF frame, then 3C sent complete.
      step(1'b0, 1'b1, 8'hFF, 1'b0, 1'b1, 1'b1);
      step(1'b0, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);
      for (int c = 0; c < 11; c++) step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

      // Reset and valid on the same idle edge: accepted on the next edge.
      step(1'b1, 1'b1, 8'h5A, 1'b1, 1'b1, 1'b1);
      step(1'b0, 1'b1, 8'h5A, 1'b0, 1'b1, 1'b1);
      step(1'b0, 1'b0, 8'h5A, 1'b0, 1'b0, 1'b1);
      for (int c = 0; c < 10; c++) step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

      // Randomized traffic with occasional resets (including during DONE).
      for (int c = 0; c < 3000; c++) begin
         step(($urandom_range(0, 39) == 0), 1'($urandom_range(0, 1)), 8'($urandom),
              ($urandom_range(0, 29) == 0), 1'($urandom_range(0, 1)), 1'($urandom));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
